// File: rtl/memory_game_ctrl.sv
// Pairs-game state controller: card grid, cursor, flip/match FSM and move counter on the pixel clock.
// Optional DEBOUNCE_EN: button presses are judged only on frame-pulse samples.
module memory_game_ctrl #(
  parameter int COLS        = 5,
  parameter int ROWS        = 4,
  parameter int IDX_W       = $clog2(COLS*ROWS),
  parameter int HOLD_FRAMES = 60,
  parameter int MOVES_W     = 10
) (
  input  logic                        clock_25M,
  input  logic                        reset_n,
  input  logic                        frame,
  input  logic                        select,
  input  logic                        move_x,
  input  logic                        move_y,
  input  logic [COLS*ROWS*IDX_W-1:0]  card_order,
  input  logic [IDX_W-1:0]            rd_pos,
  output logic [1:0]                  rd_state,
  output logic [IDX_W-1:0]            rd_id,
  output logic [IDX_W-1:0]            cursor,
  output logic [MOVES_W-1:0]          moves,
  output logic                        busy,
  output logic                        game_over
);

  localparam int N     = COLS*ROWS;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int TMR_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  localparam logic [COL_W-1:0]   COL_MAX   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]   ROW_MAX   = ROW_W'(ROWS - 1);
  localparam logic [IDX_W:0]     N_EXT     = (IDX_W+1)'(N);
  localparam logic [TMR_W-1:0]   HOLD_LAST = TMR_W'(HOLD_FRAMES);
  localparam logic [MOVES_W-1:0] MOVES_SAT = {MOVES_W{1'b1}};

  localparam logic [1:0] ST_HIDDEN  = 2'd0;
  localparam logic [1:0] ST_UP      = 2'd1;
  localparam logic [1:0] ST_REMOVED = 2'd2;

  if (N % 2 != 0) begin : g_bad_grid
    $error("memory_game_ctrl: COLS*ROWS must be even");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ONE,
    S_HOLD
  } fsm_t;

  // Button bit order: {select, move_y, move_x}; raw buttons idle high.
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] btn_prev;
  logic [2:0] press;
  logic       press_sel;
  logic       press_y;
  logic       press_x;

  always_ff @(posedge clock_25M or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 3'b111;
      sync2 <= 3'b111;
    end else begin
      sync1 <= {select, move_y, move_x};
      sync2 <= sync1;
    end
  end

`ifdef DEBOUNCE_EN
  // Level is only looked at on frame pulses, so bounce shorter than a frame is ignored.
  always_ff @(posedge clock_25M or negedge reset_n) begin
    if (!reset_n) begin
      btn_prev <= 3'b111;
    end else if (frame) begin
      btn_prev <= sync2;
    end
  end

  assign press = frame ? (btn_prev & ~sync2) : 3'b000;
`else
  always_ff @(posedge clock_25M or negedge reset_n) begin
    if (!reset_n) begin
      btn_prev <= 3'b111;
    end else begin
      btn_prev <= sync2;
    end
  end

  assign press = btn_prev & ~sync2;
`endif

  assign press_sel = press[2];
  assign press_y   = press[1];
  assign press_x   = press[0];

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col_next;
  logic [ROW_W-1:0] row_next;

  always_comb begin
    col_next = col;
    row_next = row;
    if (press_x) begin
      col_next = (col == '0) ? COL_MAX : col - COL_W'(1);
    end
    if (press_y) begin
      row_next = (row == ROW_MAX) ? '0 : row + ROW_W'(1);
    end
  end

  // Cursor keeps moving in every FSM state, including after the game ends.
  always_ff @(posedge clock_25M or negedge reset_n) begin
    if (!reset_n) begin
      col    <= '0;
      row    <= '0;
      cursor <= '0;
    end else begin
      col    <= col_next;
      row    <= row_next;
      cursor <= IDX_W'(int'(col_next) * ROWS + int'(row_next));
    end
  end

  fsm_t             fsm;
  logic [1:0]       card_state [N];
  logic [IDX_W-1:0] first_pos;
  logic [IDX_W-1:0] second_pos;
  logic [TMR_W-1:0] timer;
  logic [IDX_W:0]   removed_cnt;

  logic [IDX_W-1:0] cur_id;
  logic [IDX_W-1:0] first_id;
  logic [1:0]       cur_state;
  logic             pair_match;
  logic [IDX_W:0]   removed_next;

  assign cur_id       = card_order[int'(cursor) * IDX_W +: IDX_W];
  assign first_id     = card_order[int'(first_pos) * IDX_W +: IDX_W];
  assign cur_state    = card_state[cursor];
  assign pair_match   = (cur_id >> 1) == (first_id >> 1);
  assign removed_next = removed_cnt + (IDX_W+1)'(2);

  always_ff @(posedge clock_25M or negedge reset_n) begin
    if (!reset_n) begin
      fsm         <= S_IDLE;
      first_pos   <= '0;
      second_pos  <= '0;
      timer       <= '0;
      removed_cnt <= '0;
      moves       <= '0;
      busy        <= 1'b0;
      game_over   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        card_state[i] <= ST_HIDDEN;
      end
    end else begin
      unique case (fsm)
        S_IDLE: begin
          if (press_sel && !game_over && cur_state == ST_HIDDEN) begin
            card_state[cursor] <= ST_UP;
            first_pos          <= cursor;
            fsm                <= S_ONE;
          end
        end

        S_ONE: begin
          // The first card is face up, so the hidden test also rejects re-selecting it.
          if (press_sel && !game_over && cur_state == ST_HIDDEN && cursor != first_pos) begin
            if (moves != MOVES_SAT) begin
              moves <= moves + MOVES_W'(1);
            end
            if (pair_match) begin
              card_state[first_pos] <= ST_REMOVED;
              card_state[cursor]    <= ST_REMOVED;
              removed_cnt           <= removed_next;
              if (removed_next == N_EXT) begin
                game_over <= 1'b1;
              end
              fsm <= S_IDLE;
            end else begin
              card_state[cursor] <= ST_UP;
              second_pos         <= cursor;
              timer              <= '0;
              busy               <= 1'b1;
              fsm                <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          if (timer == HOLD_LAST) begin
            card_state[first_pos]  <= ST_HIDDEN;
            card_state[second_pos] <= ST_HIDDEN;
            busy                   <= 1'b0;
            fsm                    <= S_IDLE;
          end else if (frame) begin
            timer <= timer + TMR_W'(1);
          end
        end

        default: begin
          fsm  <= S_IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

  // Painter read port: one-cycle registered lookup, out-of-range positions read as hidden id 0.
  always_ff @(posedge clock_25M or negedge reset_n) begin
    if (!reset_n) begin
      rd_state <= ST_HIDDEN;
      rd_id    <= '0;
    end else if ({1'b0, rd_pos} < N_EXT) begin
      rd_state <= card_state[rd_pos];
      rd_id    <= card_order[int'(rd_pos) * IDX_W +: IDX_W];
    end else begin
      rd_state <= ST_HIDDEN;
      rd_id    <= '0;
    end
  end

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Directed bench for memory_game_ctrl: 5x4 grid, identity card order, 3-frame mismatch hold.
module tb_memory_game_ctrl;

  localparam int COLS        = 5;
  localparam int ROWS        = 4;
  localparam int N           = COLS * ROWS;
  localparam int IDX_W       = 5;
  localparam int HOLD_FRAMES = 3;
  localparam int MOVES_W     = 10;

  logic                  clock_25M;
  logic                  reset_n;
  logic                  frame;
  logic                  select;
  logic                  move_x;
  logic                  move_y;
  logic [N*IDX_W-1:0]    card_order;
  logic [IDX_W-1:0]      rd_pos;
  logic [1:0]            rd_state;
  logic [IDX_W-1:0]      rd_id;
  logic [IDX_W-1:0]      cursor;
  logic [MOVES_W-1:0]    moves;
  logic                  busy;
  logic                  game_over;

  int checks = 0;
  int errors = 0;

  logic [1:0]       st;
  logic [IDX_W-1:0] id;

  memory_game_ctrl #(
    .COLS        (COLS),
    .ROWS        (ROWS),
    .IDX_W       (IDX_W),
    .HOLD_FRAMES (HOLD_FRAMES),
    .MOVES_W     (MOVES_W)
  ) dut (
    .clock_25M  (clock_25M),
    .reset_n    (reset_n),
    .frame      (frame),
    .select     (select),
    .move_x     (move_x),
    .move_y     (move_y),
    .card_order (card_order),
    .rd_pos     (rd_pos),
    .rd_state   (rd_state),
    .rd_id      (rd_id),
    .cursor     (cursor),
    .moves      (moves),
    .busy       (busy),
    .game_over  (game_over)
  );

  initial begin
    clock_25M = 1'b0;
    forever #20 clock_25M = ~clock_25M;
  end

  initial begin
    for (int p = 0; p < N; p++) begin
      card_order[p*IDX_W +: IDX_W] = IDX_W'(p);
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Active-high request bits; drives the active-low buttons low together, then releases.
  task automatic apply_stimulus(input logic s, input logic mx, input logic my);
    @(negedge clock_25M);
    select = ~s;
    move_x = ~mx;
    move_y = ~my;
    repeat (4) @(posedge clock_25M);
    @(negedge clock_25M);
    select = 1'b1;
    move_x = 1'b1;
    move_y = 1'b1;
    repeat (4) @(posedge clock_25M);
    @(negedge clock_25M);
  endtask

  task automatic pulse_frame();
    @(negedge clock_25M);
    frame = 1'b1;
    @(negedge clock_25M);
    frame = 1'b0;
  endtask

  task automatic read_card(input int p, output logic [1:0] s, output logic [IDX_W-1:0] i);
    @(negedge clock_25M);
    rd_pos = IDX_W'(p);
    @(negedge clock_25M);
    s = rd_state;
    i = rd_id;
  endtask

  task automatic check_card(input string tag, input int p, input int exp_state);
    logic [1:0]       s;
    logic [IDX_W-1:0] i;
    read_card(p, s, i);
    check_output(tag, 32'(s), exp_state);
  endtask

  initial begin
    int pairs;
    select  = 1'b1;
    move_x  = 1'b1;
    move_y  = 1'b1;
    frame   = 1'b0;
    rd_pos  = '0;
    reset_n = 1'b1;
    #5 reset_n = 1'b0;
    repeat (2) @(negedge clock_25M);

    check_output("rst_cursor", 32'(cursor), 0);
    check_output("rst_moves", 32'(moves), 0);
    check_output("rst_busy", 32'(busy), 0);
    check_output("rst_game_over", 32'(game_over), 0);
    check_output("rst_rd_state", 32'(rd_state), 0);
    check_output("rst_rd_id", 32'(rd_id), 0);

    @(negedge clock_25M);
    reset_n = 1'b1;
    for (int p = 0; p < N; p++) begin
      read_card(p, st, id);
      check_output("init_state", 32'(st), 0);
      check_output("init_id", 32'(id), p);
    end

    // Cursor navigation: column-major, move_x decrements column, move_y increments row.
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output("move_x_wrap", 32'(cursor), 16);
    repeat (4) apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output("move_x_cycle", 32'(cursor), 0);

    @(negedge clock_25M);
    move_y = 1'b0;
    repeat (2) @(posedge clock_25M);
    @(negedge clock_25M);
    check_output("latency_edge2", 32'(cursor), 0);
    @(negedge clock_25M);
    check_output("latency_edge3", 32'(cursor), 1);
    move_y = 1'b1;
    repeat (4) @(posedge clock_25M);

    repeat (2) apply_stimulus(1'b0, 1'b0, 1'b1);
    check_output("move_y_to_3", 32'(cursor), 3);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    check_output("move_y_wrap", 32'(cursor), 0);
    repeat (4) apply_stimulus(1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    check_output("cursor_at_5", 32'(cursor), 5);
    apply_stimulus(1'b0, 1'b1, 1'b1);
    check_output("move_xy_both", 32'(cursor), 2);
    repeat (2) apply_stimulus(1'b0, 1'b0, 1'b1);
    check_output("cursor_home", 32'(cursor), 0);

    // Matching pair at positions 0 and 1.
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_card("first_up", 0, 1);
    check_output("first_moves", 32'(moves), 0);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_card("match_removed0", 0, 2);
    check_card("match_removed1", 1, 2);
    check_output("match_moves", 32'(moves), 1);
    check_output("match_busy", 32'(busy), 0);
    check_output("match_game_over", 32'(game_over), 0);

    // Ignored selects: removed card in IDLE, removed card and first card in ONE.
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("sel_removed_idle_moves", 32'(moves), 1);
    check_card("sel_removed_idle_state", 1, 2);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_card("first2_up", 2, 1);
    repeat (3) apply_stimulus(1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("sel_removed_one_moves", 32'(moves), 1);
    check_output("sel_removed_one_busy", 32'(busy), 0);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("sel_first_moves", 32'(moves), 1);
    check_output("sel_first_busy", 32'(busy), 0);
    check_card("sel_first_state", 2, 1);

    // Mismatch 2 vs 6 (pair 1 vs pair 3) enters HOLD for three frames.
    repeat (4) apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output("cursor_at_6", 32'(cursor), 6);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("hold_busy", 32'(busy), 1);
    check_output("hold_moves", 32'(moves), 2);
    check_card("hold_first_up", 2, 1);
    check_card("hold_second_up", 6, 1);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_card("hold_sel_ignored", 7, 0);
    check_output("hold_sel_moves", 32'(moves), 2);
    check_output("hold_cursor_moves", 32'(cursor), 7);
    pulse_frame();
    check_output("hold_frame1", 32'(busy), 1);
    pulse_frame();
    check_output("hold_frame2", 32'(busy), 1);
    pulse_frame();
    check_output("hold_frame3", 32'(busy), 1);
    @(negedge clock_25M);
    check_output("hold_exit", 32'(busy), 0);
    check_card("flipback_first", 2, 0);
    check_card("flipback_second", 6, 0);
    check_card("hold_sel_not_queued", 7, 0);
    check_output("flipback_moves", 32'(moves), 2);

    // Fresh game: clear all ten pairs column by column.
    @(negedge clock_25M);
    reset_n = 1'b0;
    @(negedge clock_25M);
    reset_n = 1'b1;
    pairs = 0;
    for (int c = 0; c < COLS; c++) begin
      for (int h = 0; h < 2; h++) begin
        apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        pairs++;
        if (pairs == 9) begin
          check_output("game_over_early", 32'(game_over), 0);
        end
      end
      apply_stimulus(1'b0, 1'b1, 1'b0);
    end
    check_output("game_over_set", 32'(game_over), 1);
    check_output("game_over_moves", 32'(moves), 10);
    check_output("game_over_busy", 32'(busy), 0);
    check_output("game_over_cursor", 32'(cursor), 0);
    check_card("all_removed_0", 0, 2);
    check_card("all_removed_19", 19, 2);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    check_output("post_over_cursor", 32'(cursor), 1);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("post_over_moves", 32'(moves), 10);
    check_output("post_over_sticky", 32'(game_over), 1);

    // New game, then asynchronous reset while HOLD is active.
    @(negedge clock_25M);
    reset_n = 1'b0;
    @(negedge clock_25M);
    reset_n = 1'b1;
    apply_stimulus(1'b1, 1'b0, 1'b0);
    repeat (2) apply_stimulus(1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("hold2_busy", 32'(busy), 1);
    check_output("hold2_cursor", 32'(cursor), 2);
    check_output("hold2_moves", 32'(moves), 1);
    read_card(0, st, id);
    check_output("hold2_state0", 32'(st), 1);
    #5 reset_n = 1'b0;
    #1;
    check_output("async_busy", 32'(busy), 0);
    check_output("async_cursor", 32'(cursor), 0);
    check_output("async_moves", 32'(moves), 0);
    check_output("async_game_over", 32'(game_over), 0);
    check_output("async_rd_state", 32'(rd_state), 0);
    check_output("async_rd_id", 32'(rd_id), 0);
    @(negedge clock_25M);
    reset_n = 1'b1;
    repeat (3) pulse_frame();
    repeat (2) @(negedge clock_25M);
    check_output("post_reset_busy", 32'(busy), 0);
    check_card("post_reset_card0", 0, 0);
    check_card("post_reset_card2", 2, 0);
    check_output("post_reset_cursor", 32'(cursor), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_game_ctrl.md
# memory_game_ctrl

Parametrised game-state controller for the VGA memory (pairs) game: owns the card grid state, cursor, flip/match state machine and move counter, clocked entirely on the pixel clock. Replaces per-button edge-clocked logic with synchronised, edge-detected button inputs and adds mismatch flip-back after a frame-counted hold, move counting and game-over detection. Sits between the board buttons and the pixel painter, which queries card state per position.

## Interface
- COLS, 5, grid columns
- ROWS, 4, grid rows; N = COLS*ROWS must be even (elaboration error otherwise)
- IDX_W, $clog2(COLS*ROWS), position/card-id width
- HOLD_FRAMES, 60, frames a mismatched pair stays face up
- MOVES_W, 10, move counter width
- clock_25M  in  1  pixel clock, only clock
- reset_n  in  1  reset, asynchronous, active-low
- frame  in  1  one-cycle pulse at start of vertical blanking
- select, move_x, move_y  in  1 each  raw buttons, active-low, asynchronous
- card_order  in  N*IDX_W  card id at position p in bits [p*IDX_W +: IDX_W]; ids 2k and 2k+1 form pair k
- rd_pos  in  IDX_W  painter query position
- rd_state  out  2  state at rd_pos: 0 hidden, 1 face up, 2 removed
- rd_id  out  IDX_W  card id at rd_pos
- cursor  out  IDX_W  selected position
- moves  out  MOVES_W  pair attempts, saturating
- busy  out  1  HOLD state active
- game_over  out  1  all pairs removed

## Operation
- Position p = col*ROWS + row (column-major).
- Buttons: two-flop synchroniser, press = high-to-low transition of synchronised level.
- move_y press: row+1, ROWS-1 wraps to 0, column unchanged. move_x press: col-1, 0 wraps to COLS-1. Both in same cycle: both applied. Cursor moves in every state, including after game_over.
- FSM IDLE: select on hidden card → card face up, store pos as first, go ONE. Select on face-up/removed card ignored.
- ONE: select on hidden card → compare pair ids (id>>1) of first and cursor card; moves += 1 (saturate at all-ones). Match: both → removed, removed-count += 2, go IDLE (game_over if count == N). Mismatch: second card face up, go HOLD, clear hold timer. Select on first card or removed card ignored.
- HOLD: busy=1; timer increments on each frame pulse; when timer == HOLD_FRAMES both cards → hidden, go IDLE. HOLD_FRAMES=0 → leave HOLD on next cycle. Selects in HOLD ignored (not queued).
- game_over: sticky until reset; all selects ignored.
- card_order must be stable while reset_n high; change mid-game is undefined.

## Timing
- Reset (async assert, sync release): all cards hidden, FSM IDLE, cursor 0, moves 0, busy 0, game_over 0, rd_state 0, rd_id 0, timer 0, synchroniser flops 1.
- Button falling edge → cursor/state updated 3 cycles later (2 sync + edge register).
- rd_state/rd_id registered: value for rd_pos sampled at edge k valid after edge k.
- Match: removed state and game_over visible same cycle as moves increment.
- reset_n asserted mid-HOLD or mid-press: everything cleared immediately; no pending flip-back.

## Configuration
- DEBOUNCE_EN defined: synchronised buttons are resampled on frame pulses; press = level high on one frame sample and low on the next (max one press per button per frame, latency up to one frame + 3 cycles).
- Not defined: press detected on any cycle from the synchronised level as above; no frame dependency.

## Test plan
- Reset with identity card_order (COLS=5, ROWS=4): every rd_pos → rd_state 0, rd_id=pos; cursor 0, moves 0.
- select at 0, move_y, select at 1 → rd_state(0)=rd_state(1)=2, moves=1, busy 0.
- HOLD_FRAMES=3: select 0, move_y ×2, select 2 → both state 1, busy 1 for exactly 3 frame pulses, then both 0, moves=1; select during HOLD ignored.
- Cursor: move_x at 0 → 16; move_y at 3 → 0; simultaneous move_x+move_y at 5 → 2.
- Select on removed card or first card in ONE → no state change, moves unchanged.
- Clear all 10 pairs → game_over=1, moves=10; then reset_n low mid-HOLD in a new game → all outputs at reset values asynchronously.
